// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_s.sv
// One-bit full subtractor cell: d = x - y - bin, bo = borrow out. Purely combinational.
module full_subtractor_s (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign d       = x_xor_y ^ bin;
  assign bo      = (~x & y) | (~x_xor_y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin, LSB first) behind valid/ready handshakes.
// Optional signed-overflow output ovf is built when SUB_OVF_EN is defined.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bo;
  logic             accept, last_bit;

  full_subtractor_s u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bin(borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Working shift register is kept apart from diff so partial results never reach the output.
  generate
    if (WIDTH == 1) begin : g_sh_w1
      assign sh_next = cell_d;
    end else begin : g_sh_wn
      assign sh_next = {cell_d, sh_q[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == BUSY) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      sh_d     = '0;
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == BUSY) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      sh_d     = sh_next;
      borrow_d = cell_bo;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
        diff_d = sh_next;
        bout_d = cell_bo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the last step a_q[0]/b_q[0] hold the operand sign bits.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (last_bit) begin
      ovf_d = (a_q[0] ^ b_q[0]) & (cell_d ^ a_q[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1; ovf is checked when SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, bin8 = 1'b0, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, bin1 = 1'b0, bout1;
  logic [0:0] a1 = '0, b1 = '0, diff1;
`ifdef SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8)
`ifdef SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1)
`ifdef SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [8:0] m, am, bm, full;
    exp_t e;
    m    = (9'd1 << w) - 9'd1;
    am   = {1'b0, av} & m;
    bm   = {1'b0, bv} & m;
    full = am - bm - {8'd0, bi};
    e.d  = full[7:0] & m[7:0];
    e.bo = (am < (bm + {8'd0, bi}));
    e.ov = (am[w-1] != bm[w-1]) && (e.d[w-1] != am[w-1]);
    return e;
  endfunction

  // Issue one operand set; optionally drive junk with in_valid=1 while the DUT is busy.
  task automatic send(input bit w1, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      input bit push, input bit garb, input exp_t e);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((w1 ? in_ready1 : in_ready8) === 1'b1) break;
      if (w1) begin
        in_valid1 = garb; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      end else begin
        in_valid8 = garb; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout w1=%0d: in_ready=0 want=1", w1);
        return;
      end
    end
    if (w1) begin
      in_valid1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi;
      if (push) q1.push_back(e);
    end else begin
      in_valid8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
      if (push) q8.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w1) begin
      in_valid1 = garb; a1 = 1'($urandom); b1 = 1'($urandom);
    end else begin
      in_valid8 = garb; a8 = 8'($urandom); b8 = 8'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q1.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending8=%0d pending1=%0d want=0", q8.size(), q1.size());
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected: result diff=%h with nothing issued", diff8);
      end else begin
        e = q8.pop_front();
        $display("w8 result diff=%h bout=%b (want %h %b)", diff8, bout8, e.d, e.bo);
        chk("w8_diff", 32'(diff8), 32'(e.d));
        chk("w8_bout", 32'(bout8), 32'(e.bo));
`ifdef SUB_OVF_EN
        chk("w8_ovf", 32'(ovf8), 32'(e.ov));
`endif
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL w1_unexpected: result diff=%h with nothing issued", diff1);
      end else begin
        e = q1.pop_front();
        $display("w1 result diff=%h bout=%b (want %h %b)", diff1, bout1, e.d[0], e.bo);
        chk("w1_diff", 32'(diff1), 32'(e.d[0]));
        chk("w1_bout", 32'(bout1), 32'(e.bo));
`ifdef SUB_OVF_EN
        chk("w1_ovf", 32'(ovf1), 32'(e.ov));
`endif
      end
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        out_ready8 = 1'($urandom);
        out_ready1 = 1'($urandom);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    logic [7:0] ra8, rb8, ra1, rb1;
    logic       ri8, ri1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", 32'(ovf8), 32'd0);
`endif
    rst_n = 1'b1;

    send(1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 1'b0, '{8'h02, 1'b0, 1'b0});
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid8) break;
    end
    chk("latency", 32'(cyc), 32'd8);

    send(1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, '{8'hFF, 1'b1, 1'b0});
    send(1'b0, 8'h10, 8'h0F, 1'b1, 1'b1, 1'b0, '{8'h00, 1'b0, 1'b0});
    wait_drain();

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    send(1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 1'b0, '{8'h02, 1'b0, 1'b0});
    cyc = 0;
    while (!out_valid8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_diff", 32'(diff8), 32'h02);
      chk("bp_bout", 32'(bout8), 32'd0);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
    end
    @(posedge clk);
    #1 out_ready8 = 1'b1;
    @(negedge clk);
    chk("bp_no_reaccept", 32'(in_ready8), 32'd0);
    @(negedge clk);
    chk("bp_idle_ready", 32'(in_ready8), 32'd1);
    chk("bp_idle_valid", 32'(out_valid8), 32'd0);

    // Reset in the middle of an operation.
    send(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, '{8'h7F, 1'b0, 1'b1});
    wait_drain();

    // Random operands with random out_ready and junk offered while busy.
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra8 = 8'($urandom); rb8 = 8'($urandom); ri8 = 1'($urandom);
          send(1'b0, ra8, rb8, ri8, 1'b1, 1'b1, model(8, ra8, rb8, ri8));
        end
        in_valid8 = 1'b0;
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          ra1 = 8'($urandom_range(0, 1)); rb1 = 8'($urandom_range(0, 1)); ri1 = 1'($urandom);
          send(1'b1, ra1, rb1, ri1, 1'b1, 1'b1, model(1, ra1, rb1, ri1));
        end
        in_valid1 = 1'b0;
      end
    join
    @(negedge clk);
    rand_rdy = 1'b0;
    out_ready8 = 1'b1;
    out_ready1 = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
